// File: rtl/drv_pkg.sv
// Shared types and defaults for the driver mode scheduler.
package drv_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TR   = 3'd1,
    S_GAP  = 3'd2,
    S_TX   = 3'd3,
    S_TP   = 3'd4
  } drv_state_t;

  localparam int unsigned GAP_CYCLES_DEF = 4;
  localparam int unsigned WDT_CYCLES_DEF = 65535;

  // Counter widths cover the full legal parameter ranges.
  localparam int unsigned GAP_CNT_W = 8;
  localparam int unsigned WDT_CNT_W = 20;

endpackage

// File: rtl/drv_down_counter.sv
// Loadable saturating down-counter with a zero flag; used for gap and watchdog timing.
module drv_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/drv_mode_sched.sv
// Driver mode scheduler: IDLE -> TR -> (GAP) -> TX <-> (GAP) <-> TP, one-hot selects.
// Optional syncpulse watchdog in TX enabled by DRV_MODE_SCHED_WDT_EN.
module drv_mode_sched
  import drv_pkg::*;
#(
  parameter int unsigned WIDTH_MUX  = 16,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   syncpulse,
  input  logic [2*WIDTH_MUX-1:0] fi_phm,
  input  logic [2*WIDTH_MUX-1:0] detuning,
  output logic                   tr,
  output logic                   tx,
  output logic                   tp,
  output logic                   mode_change,
  output logic                   busy,
  output logic                   fault
);

  // Counter holds GAP_CYCLES-1 on GAP entry and exits when it reads zero.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? '0 : GAP_CNT_W'(GAP_CYCLES - 1);

  drv_state_t state, nxt, target, nxt_target;
  logic       gap_zero;
  logic       phase_eq, phase_gt;

  assign phase_eq = (fi_phm == detuning);
  assign phase_gt = (fi_phm > detuning);

  drv_down_counter #(.WIDTH(GAP_CNT_W)) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (state != S_GAP),
    .load_value (GAP_LOAD),
    .enable     (state == S_GAP),
    .zero       (gap_zero)
  );

`ifdef DRV_MODE_SCHED_WDT_EN
  localparam logic [WDT_CNT_W-1:0] WDT_LOAD = WDT_CNT_W'(WDT_CYCLES - 1);

  logic wdt_zero;
  logic wdt_trip;

  // Reloads outside TX and on every syncpulse, so it only runs down across silent TX cycles.
  drv_down_counter #(.WIDTH(WDT_CNT_W)) u_wdt_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       ((state != S_TX) || syncpulse),
    .load_value (WDT_LOAD),
    .enable     (state == S_TX),
    .zero       (wdt_zero)
  );
`else
  logic unused_wdt_cycles;
  assign unused_wdt_cycles = (WDT_CYCLES != 0);
  assign fault = 1'b0;
`endif

  function automatic drv_state_t via_gap(input drv_state_t mode);
    return (GAP_CYCLES == 0) ? mode : S_GAP;
  endfunction

  always_comb begin
    nxt        = state;
    nxt_target = target;
`ifdef DRV_MODE_SCHED_WDT_EN
    wdt_trip   = 1'b0;
`endif
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) nxt = S_TR;
        S_TR: begin
          if (syncpulse) begin
            nxt        = via_gap(S_TX);
            nxt_target = S_TX;
          end
        end
        S_GAP: if (gap_zero) nxt = target;
        S_TX: begin
          if (phase_eq) begin
            nxt        = via_gap(S_TP);
            nxt_target = S_TP;
          end
`ifdef DRV_MODE_SCHED_WDT_EN
          else if (wdt_zero && !syncpulse) begin
            nxt      = S_IDLE;
            wdt_trip = 1'b1;
          end
`endif
        end
        S_TP: begin
          if (phase_gt) begin
            nxt        = via_gap(S_TX);
            nxt_target = S_TX;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      target      <= S_TX;
      tr          <= 1'b0;
      tx          <= 1'b0;
      tp          <= 1'b0;
      mode_change <= 1'b0;
`ifdef DRV_MODE_SCHED_WDT_EN
      fault       <= 1'b0;
`endif
    end else begin
      state       <= nxt;
      target      <= nxt_target;
      tr          <= (nxt == S_TR);
      tx          <= (nxt == S_TX);
      tp          <= (nxt == S_TP);
      mode_change <= (nxt != state) &&
                     ((nxt == S_TR) || (nxt == S_TX) || (nxt == S_TP));
`ifdef DRV_MODE_SCHED_WDT_EN
      if (wdt_trip) begin
        fault <= 1'b1;
      end else if (state == S_IDLE && nxt == S_TR) begin
        fault <= 1'b0;
      end
`endif
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: doc/drv_mode_sched.md
DRV_MODE_SCHED -- requirements
Module: drv_mode_sched

Interface
REQ-001 SHALL have parameter WIDTH_MUX, default 16; half-width of phase operands (operands are 2*WIDTH_MUX bits).
REQ-002 SHALL have parameter GAP_CYCLES, default 4; number of dead cycles inserted on every mode switch, range 0..255.
REQ-003 SHALL have parameter WDT_CYCLES, default 65535; syncpulse watchdog limit in clk cycles, range 1..2^20-1.
REQ-004 SHALL have port clk  input  1  rising-edge system clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  level; leaves IDLE and begins the TR mode.
REQ-007 SHALL have port abort  input  1  level; forces return to IDLE.
REQ-008 SHALL have port syncpulse  input  1  one-cycle sync event from the timing source.
REQ-009 SHALL have port fi_phm  input  2*WIDTH_MUX  measured phase, unsigned.
REQ-010 SHALL have port detuning  input  2*WIDTH_MUX  phase target, unsigned.
REQ-011 SHALL have ports tr, tx, tp  output  1 each  registered one-hot mode selects to the driver mux.
REQ-012 SHALL have port mode_change  output  1  one-cycle pulse on the first cycle of each new active mode.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port fault  output  1  sticky watchdog fault flag.

Function
- REQ-015 SHALL implement the states IDLE, TR, GAP, TX and TP, plus a registered next-mode target used by GAP.
- REQ-016 Outputs: tr=1 only in TR, tx=1 only in TX, tp=1 only in TP; all three 0 in IDLE and GAP; at most one high in any cycle.
- REQ-017 IDLE: start=1 -> TR on the next cycle; TR is entered directly, with no GAP.
- REQ-018 TR: syncpulse=1 -> GAP with target TX.
- REQ-019 TX: fi_phm == detuning -> GAP with target TP; a syncpulse in TX stays in TX and restarts the watchdog counter.
- REQ-020 TX, simultaneous equality and syncpulse: equality wins (go to GAP/TP).
- REQ-021 TP: fi_phm > detuning (unsigned, full 2*WIDTH_MUX width) -> GAP with target TX; otherwise stay in TP.
- REQ-022 GAP: stays GAP_CYCLES cycles (counter loaded on entry), then enters the target; GAP_CYCLES=0 skips GAP, so the target mode is entered on the cycle after the trigger.
- REQ-023 mode_change SHALL pulse for exactly one cycle on entry to TR, TX or TP, registered and aligned with the new select; it SHALL NOT pulse on entry to IDLE or GAP.
- REQ-024 abort=1 in any state -> IDLE on the next cycle; abort overrides start and all other transitions; while abort is held, the block stays in IDLE.
- REQ-025 Inputs to the transition logic are used as-is (already synchronous); the latency from trigger to the next state is 1 cycle.

Reset
- REQ-026 rst SHALL force, on the next clock edge: state IDLE; tr=tx=tp=0; mode_change=0; busy=0; fault=0; gap and watchdog counters=0.
- REQ-027 rst asserted mid-operation (any state, including GAP) SHALL give the same result as REQ-026, and no mode_change pulse SHALL follow.

Configuration
- REQ-028 Macro DRV_MODE_SCHED_WDT_EN defined: in TX, if WDT_CYCLES consecutive cycles pass without a syncpulse, the block SHALL go to IDLE and set fault; fault stays high until rst, or until start is accepted in IDLE.
- REQ-029 Macro DRV_MODE_SCHED_WDT_EN undefined: the watchdog counter SHALL be absent, fault SHALL be tied to 0, and WDT_CYCLES SHALL be ignored.

Structure
- REQ-030 The state enum (IDLE, TR, GAP, TX, TP) and the GAP_CYCLES/WDT_CYCLES defaults SHALL live in the shared package drv_pkg.
- REQ-031 The gap/watchdog down-counter SHALL be one sub-module, drv_down_counter (load, enable, zero flag), instantiated once for the gap and once for the watchdog when DRV_MODE_SCHED_WDT_EN is defined.
- REQ-032 The outputs SHALL connect directly to the tr/tx/tp inputs of the existing driver mux.

Verification
- REQ-033 Reset, then start=1 -> tr=1 and mode_change=1 one cycle later; busy=1.
- REQ-034 In TR, syncpulse, GAP_CYCLES=4 -> 4 cycles with tr=tx=tp=0, then tx=1 with a mode_change pulse.
- REQ-035 In TX, fi_phm=detuning=0x0000_1234 together with a syncpulse in the same cycle -> GAP, then tp=1; in TP, fi_phm=0x0000_1235 -> GAP, then tx=1.
- REQ-036 abort asserted in the 2nd GAP cycle -> IDLE next cycle, all selects 0, no mode_change; rst asserted in TP -> all outputs 0 next cycle.
- REQ-037 With DRV_MODE_SCHED_WDT_EN and WDT_CYCLES=100, no syncpulse in TX for 100 cycles -> IDLE and fault=1; the next start clears fault.
- REQ-038 GAP_CYCLES=0 build: a TR syncpulse -> tx=1 on the very next cycle.
